// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// default AXI response / substitute instruction values, and a small helper.
package ifu_fetch_pkg;

  // Fetch FSM states; at most one AXI read is outstanding at any time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting to issue the next fetch
    ST_ADDR = 2'd1,  // read address presented, waiting for arready
    ST_DATA = 2'd2,  // waiting for the read response
    ST_HOLD = 2'd3   // instruction presented to ID, waiting for acceptance
  } fetch_state_e;

  // rresp value that marks a good fetch.
  localparam logic [1:0]  RESP_OK_DEF  = 2'b00;

  // Instruction substituted when the fetch faults (addi x0, x0, 0).
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // True when a read response must be treated as a faulted fetch.
  function automatic logic resp_is_fault(input logic [1:0] resp,
                                         input logic [1:0] ok_code);
    return (resp != ok_code);
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one AXI read per instruction at the PC
// supplied by the PC unit, captures the response into a registered bundle
// for the ID stage and holds it there until ID accepts it.
//
// Handshake rules:
//   AXI AR : arvalid rises in ADDR and stays high with araddr stable until
//            arvalid && arready; a redirect never retracts it.
//   AXI R  : rready is high for the whole of DATA; a beat transfers on
//            rvalid && rready.
//   ID     : if_id_valid is high for the whole of HOLD with if_id_* stable;
//            the bundle is consumed on if_id_valid && if_id_ready &&
//            ~if_id_stall. The PC unit uses the same condition through
//            if_idle to advance.
// A redirect (pc_b_j) while a read is in flight marks it as dropped: the
// read still completes on the bus but its data never reaches ID.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [1:0]  RESP_OK  = RESP_OK_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,

  // PC unit
  input  logic [31:0] pc,
  input  logic        pc_b_j,
  output logic        if_idle,

  // ID stage flow control
  input  logic        if_id_stall,
  input  logic        if_id_ready,

  // AXI read-address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,

  // AXI read-data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,

  // Fetched-instruction bundle to ID
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_fault,

  // Debug view of the fetch FSM
  output logic [1:0]  dbg_state_o
);

  fetch_state_e state_q, state_d;

  logic [31:0] req_pc_q,   req_pc_d;
  logic        drop_q,     drop_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_fault_q, id_fault_d;

  // Request may be issued from IDLE only when ID is not stalled and no
  // redirect is being signalled this cycle.
  logic issue_ok;
  assign issue_ok = ~if_id_stall & ~pc_b_j;

  // The bundle leaves HOLD when ID takes it.
  logic id_accept;
  assign id_accept = if_id_ready & ~if_id_stall;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arvalid is high throughout ADDR, so arready alone
  // completes the address handshake there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_ok) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (rvalid) begin
          if (drop_q || pc_b_j) state_d = ST_IDLE;
          else                  state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (pc_b_j || id_accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded directly from the current state.
  always_comb begin
    arvalid     = 1'b0;
    rready      = 1'b0;
    if_id_valid = 1'b0;
    if_idle     = 1'b0;
    case (state_q)
      ST_ADDR: arvalid = 1'b1;
      ST_DATA: rready  = 1'b1;
      ST_HOLD: begin
        if_id_valid = 1'b1;
        if_idle     = 1'b1;
      end
      default: begin
        arvalid     = 1'b0;
        rready      = 1'b0;
        if_id_valid = 1'b0;
        if_idle     = 1'b0;
      end
    endcase
  end

  // Datapath next values: request address latch, drop flag, response capture.
  always_comb begin
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_fault_d = id_fault_q;

    case (state_q)
      ST_IDLE: begin
        if (issue_ok) req_pc_d = pc;
      end
      ST_ADDR: begin
        if (pc_b_j) drop_d = 1'b1;
      end
      ST_DATA: begin
        if (pc_b_j) drop_d = 1'b1;
        // Only a response that will be presented to ID updates the bundle,
        // so a dropped read leaves the previous values untouched.
        if (rvalid && !drop_q && !pc_b_j) begin
          id_pc_d = req_pc_q;
          if (resp_is_fault(rresp, RESP_OK)) begin
            id_inst_d  = NOP_INST;
            id_fault_d = 1'b1;
          end else begin
            id_inst_d  = rdata;
            id_fault_d = 1'b0;
          end
        end
      end
      default: begin
        drop_d = drop_q;
      end
    endcase

    // Every path back to IDLE starts the next fetch with a clean drop flag.
    if (state_d == ST_IDLE) drop_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc_q   <= 32'h0;
      drop_q     <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
      id_fault_q <= 1'b0;
    end else begin
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_fault_q <= id_fault_d;
    end
  end

  // The address is only updated in IDLE, so it stays stable through ADDR.
  assign araddr      = req_pc_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_inst  = id_inst_q;
  assign if_id_fault = id_fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: the bench acts as PC unit, ID stage and AXI memory.
// Each fetch is described by its address, wait states and response; the
// expected timeline and bundle come from plain arithmetic on those values.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_b_j;
  logic        if_id_stall;
  logic        if_id_ready;
  logic        if_idle;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_fault;
  logic [1:0]  dbg_state;

  int n_asrt = 0;
  int n_fail = 0;
  int ar_hs  = 0;
  int r_hs   = 0;

  // Expected bundles: {fault, pc, inst}
  logic [64:0] exp_q[$];

  ifu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_b_j      (pc_b_j),
    .if_idle     (if_idle),
    .if_id_stall (if_id_stall),
    .if_id_ready (if_id_ready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_fault (if_id_fault),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus handshake counters
  always @(posedge clk) begin
    if (rst) begin
      if (arvalid && arready) ar_hs = ar_hs + 1;
      if (rvalid && rready)   r_hs  = r_hs + 1;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = $urandom;
    rresp   = 2'($urandom_range(0, 3));
  endtask

  // Hold reset for a few cycles, check reset values, release at a negedge.
  task automatic do_reset();
    rst = 1'b0;
    pc = 32'h0; pc_b_j = 1'b0; if_id_stall = 1'b0; if_id_ready = 1'b0;
    bus_idle();
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'h0);
    chk("rst_rready",  32'(rready), 32'h0);
    chk("rst_valid",   32'(if_id_valid), 32'h0);
    chk("rst_fault",   32'(if_id_fault), 32'h0);
    chk("rst_idle",    32'(if_idle), 32'h0);
    chk("rst_araddr",  araddr, 32'h0);
    chk("rst_id_pc",   if_id_pc, 32'h0);
    chk("rst_id_inst", if_id_inst, NOP);
    ar_hs = 0;
    r_hs  = 0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  // One complete fetch, starting at a negedge while the DUT is idle.
  // iw: idle cycles blocked by stall/redirect, aw: arready wait,
  // rw: rvalid wait, hw: cycles ID holds off, hflush: leave HOLD by redirect.
  task automatic fetch_txn(input logic [31:0] addr, input int aw, input int rw,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int iw, input int hw, input bit hflush);
    logic        ef;
    logic [31:0] ei;
    logic [64:0] e;
    int          hs0, rs0, rp;
    ef = (resp != 2'b00);
    ei = ef ? NOP : data;
    exp_q.push_back({ef, addr, ei});
    hs0 = ar_hs;
    rs0 = r_hs;
    rp  = 2 + aw + rw;

    for (int i = 0; i < iw; i++) begin
      pc = addr;
      if (if_id_ready) if_id_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) begin if_id_stall = 1'b1; pc_b_j = 1'b0; end
      else begin if_id_stall = 1'b0; pc_b_j = 1'b1; end
      bus_idle();
      next_cycle();
      chk("idle_blocked_arvalid", 32'(arvalid), 32'h0);
    end

    for (int p = 0; p <= rp; p++) begin
      if (p >= 1) begin
        chk("ar_valid", 32'(arvalid), 32'((p <= 1 + aw) ? 1 : 0));
        if (p <= 1 + aw) chk("ar_addr", araddr, addr);
        chk("r_ready", 32'(rready), 32'((p >= 2 + aw) ? 1 : 0));
        chk("pre_valid", 32'(if_id_valid), 32'h0);
      end
      pc_b_j      = 1'b0;
      if_id_stall = 1'b0;
      if (p == 0) begin
        pc = addr;
        if_id_ready = 1'b0;
      end else begin
        pc = $urandom;
        if_id_ready = 1'($urandom_range(0, 1));
      end
      arready = (p == 1 + aw);
      rvalid  = (p == rp);
      rdata   = rvalid ? data : $urandom;
      rresp   = rvalid ? resp : 2'($urandom_range(0, 3));
      next_cycle();
    end
    bus_idle();

    e = exp_q[0];
    for (int h = 0; h <= hw; h++) begin
      chk("hold_valid",   32'(if_id_valid), 32'h1);
      chk("hold_idle",    32'(if_idle), 32'h1);
      chk("hold_arvalid", 32'(arvalid), 32'h0);
      chk("hold_pc",      if_id_pc, e[63:32]);
      chk("hold_inst",    if_id_inst, e[31:0]);
      chk("hold_fault",   32'(if_id_fault), 32'(e[64]));
      if (h < hw) begin
        pc_b_j = 1'b0;
        case ($urandom_range(0, 2))
          0: begin if_id_ready = 1'b0; if_id_stall = 1'b0; end
          1: begin if_id_ready = 1'b0; if_id_stall = 1'b1; end
          default: begin if_id_ready = 1'b1; if_id_stall = 1'b1; end
        endcase
      end else if (hflush) begin
        pc_b_j = 1'b1; if_id_ready = 1'b0;
        if_id_stall = 1'($urandom_range(0, 1));
      end else begin
        pc_b_j = 1'b0; if_id_ready = 1'b1; if_id_stall = 1'b0;
      end
      next_cycle();
    end
    void'(exp_q.pop_front());

    chk("post_valid",   32'(if_id_valid), 32'h0);
    chk("post_idle",    32'(if_idle), 32'h0);
    chk("post_arvalid", 32'(arvalid), 32'h0);
    chk("ar_hs_count",  32'(ar_hs - hs0), 32'h1);
    chk("r_hs_count",   32'(r_hs - rs0), 32'h1);
    pc_b_j = 1'b0; if_id_ready = 1'b0; if_id_stall = 1'b0;
  endtask

  // A fetch redirected in flight: pc_b_j pulses in period fp (ADDR or DATA).
  // The read must complete on the bus and never reach ID; pc then holds naddr.
  task automatic flush_txn(input logic [31:0] addr, input logic [31:0] naddr,
                           input int aw, input int rw, input int fp);
    int hs0, rs0, rp;
    hs0 = ar_hs;
    rs0 = r_hs;
    rp  = 2 + aw + rw;
    for (int p = 0; p <= rp; p++) begin
      if (p >= 1) begin
        chk("fl_ar_valid", 32'(arvalid), 32'((p <= 1 + aw) ? 1 : 0));
        if (p <= 1 + aw) chk("fl_ar_addr", araddr, addr);
        chk("fl_r_ready", 32'(rready), 32'((p >= 2 + aw) ? 1 : 0));
        chk("fl_valid", 32'(if_id_valid), 32'h0);
      end
      if_id_stall = 1'b0;
      if_id_ready = 1'b0;
      pc_b_j      = (p == fp);
      pc          = (p >= fp) ? naddr : addr;
      arready     = (p == 1 + aw);
      rvalid      = (p == rp);
      rdata       = $urandom;
      rresp       = 2'($urandom_range(0, 3));
      next_cycle();
    end
    bus_idle();
    pc_b_j = 1'b0;
    chk("fl_post_valid",   32'(if_id_valid), 32'h0);
    chk("fl_post_arvalid", 32'(arvalid), 32'h0);
    chk("fl_post_rready",  32'(rready), 32'h0);
    chk("fl_ar_hs_count",  32'(ar_hs - hs0), 32'h1);
    chk("fl_r_hs_count",   32'(r_hs - rs0), 32'h1);
  endtask

  initial begin
    logic [31:0] cur;
    int aw, rw;

    do_reset();

    // Zero-wait fetch: bundle presented three cycles after reset release.
    fetch_txn(32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 0, 0, 1'b0);

    // arready held off for 4 cycles.
    fetch_txn(32'h8000_0004, 4, 0, 32'h0020_0113, 2'b00, 0, 0, 1'b0);

    // Error response substitutes the NOP and flags the fault.
    fetch_txn(32'h8000_0008, 1, 2, 32'hdead_beef, 2'b10, 0, 0, 1'b0);

    // ID holds off for 3 cycles, then the next fetch goes to pc+4.
    fetch_txn(32'h8000_000c, 0, 1, 32'h0030_0193, 2'b00, 0, 3, 1'b0);
    fetch_txn(32'h8000_0010, 0, 0, 32'h0040_0213, 2'b00, 2, 0, 1'b0);

    // Redirect in DATA before rvalid, then fetch from the new target.
    flush_txn(32'h8000_0014, 32'h8000_0100, 1, 3, 4);
    fetch_txn(32'h8000_0100, 0, 0, 32'h0050_0293, 2'b00, 0, 0, 1'b0);

    // Redirect in ADDR while arready is held off.
    flush_txn(32'h8000_0104, 32'h8000_0200, 3, 1, 2);
    fetch_txn(32'h8000_0200, 1, 1, 32'h0060_0313, 2'b01, 0, 1, 1'b0);

    // Redirect coincident with rvalid, and redirect out of HOLD.
    flush_txn(32'h8000_0204, 32'h8000_0300, 0, 2, 4);
    fetch_txn(32'h8000_0300, 0, 0, 32'h0070_0393, 2'b00, 0, 2, 1'b1);

    // Reset asserted while the address is outstanding.
    pc = 32'h8000_0400; pc_b_j = 1'b0; if_id_stall = 1'b0; if_id_ready = 1'b0;
    bus_idle();
    next_cycle();
    chk("mid_arvalid", 32'(arvalid), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_arvalid", 32'(arvalid), 32'h0);
    chk("async_araddr",  araddr, 32'h0);
    chk("async_rready",  32'(rready), 32'h0);
    do_reset();
    fetch_txn(32'h8000_0400, 0, 0, 32'h0080_0413, 2'b00, 0, 0, 1'b0);

    // Randomized traffic.
    cur = 32'h8000_1000;
    for (int t = 0; t < 30; t++) begin
      aw = $urandom_range(0, 4);
      rw = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        flush_txn(cur, cur + 32'h100, aw, rw, $urandom_range(1, 2 + aw + rw));
        cur = cur + 32'h100;
      end else begin
        fetch_txn(cur, aw, rw, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2), $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0));
        cur = cur + 32'h4;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESP_OK, default 2'b00, meaning the AXI rresp value that marks a good fetch.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, meaning the instruction word substituted on a faulted fetch.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port pc  input  32  fetch address from the PC unit.
REQ-006 SHALL have port pc_b_j  input  1  redirect/flush; the current fetch is discarded.
REQ-007 SHALL have port if_id_stall  input  1  the ID stage holds; no new fetch is issued and HOLD is not released.
REQ-008 SHALL have port if_id_ready  input  1  the ID stage accepts if_id_* this cycle.
REQ-009 SHALL have port if_idle  output  1  high in HOLD; the PC unit advances on if_idle && if_id_ready && ~if_id_stall.
REQ-010 SHALL have ports araddr (output, 32), arvalid (output, 1) and arready (input, 1): the AXI read-address channel.
REQ-011 SHALL have ports rdata (input, 32), rresp (input, 2), rvalid (input, 1) and rready (output, 1): the AXI read-data channel.
REQ-012 SHALL have ports if_id_valid (output, 1), if_id_pc (output, 32), if_id_inst (output, 32) and if_id_fault (output, 1): the fetched-instruction bundle sent to ID.

Function
REQ-013 SHALL implement the FSM IDLE, ADDR, DATA, HOLD, with at most one outstanding read.
REQ-014 IDLE SHALL latch pc into req_pc and go to ADDR when ~if_id_stall && ~pc_b_j; otherwise it SHALL stay in IDLE.
REQ-015 ADDR SHALL drive arvalid=1 and araddr=req_pc, holding both stable until arready; on arvalid&&arready it SHALL go to DATA.
REQ-016 DATA SHALL drive rready=1; on rvalid it SHALL go to IDLE if the drop flag is set or pc_b_j=1, and otherwise to HOLD.
REQ-017 On an rvalid capture, if_id_inst SHALL be rdata, or NOP_INST with if_id_fault=1 when rresp!=RESP_OK; if_id_pc SHALL be req_pc.
REQ-018 HOLD SHALL drive if_id_valid=1 and keep if_id_* stable.
REQ-019 HOLD SHALL go to IDLE on if_id_ready && ~if_id_stall; otherwise it SHALL stay in HOLD.
REQ-020 pc_b_j in ADDR SHALL keep arvalid asserted until the handshake (no AXI retraction) and SHALL set the drop flag.
REQ-021 pc_b_j in DATA SHALL set the drop flag, so the response is still consumed (rready=1) and then discarded.
REQ-022 pc_b_j in HOLD SHALL clear if_id_valid the next cycle and go to IDLE.
REQ-023 pc_b_j in IDLE SHALL have no effect except blocking the request that cycle.
REQ-024 The drop flag SHALL clear on entering IDLE.
REQ-025 Latency SHALL be: request issued 1 cycle after IDLE, plus the arready wait, plus the rvalid wait, then if_id_valid 1 cycle after rvalid; minimum 3 cycles from IDLE to HOLD with zero-wait memory.
REQ-026 Outputs SHALL come from registers or a state decode only; there SHALL be no combinational path from rdata to if_id_inst.

Reset
REQ-027 With rst=0 (async), the FSM SHALL be IDLE, and arvalid, rready, if_id_valid, if_id_fault, the drop flag and if_idle SHALL be 0.
REQ-028 With rst=0 (async), araddr, req_pc and if_id_pc SHALL be 32'h0 and if_id_inst SHALL be NOP_INST.
REQ-029 Reset asserted mid-transaction SHALL abandon it; the memory model is reset together with this block.

Structure
REQ-030 The FSM state encoding and RESP_OK/NOP_INST defaults SHALL live in common.v.
REQ-031 The block SHALL be a single module with no sub-modules; it connects to pcu via pc, pc_b_j and if_idle.

Verification
REQ-032 Zero-wait memory, pc=0x80000000, rdata=0x00100093: if_id_valid=1 with inst 0x00100093 and pc 0x80000000 three cycles after reset release; if_idle=1.
REQ-033 arready delayed 4 cycles: arvalid held high with araddr constant for all 4 cycles; exactly one AR handshake occurs.
REQ-034 pc_b_j pulsed in DATA before rvalid: the response is consumed, if_id_valid never rises, and the next request uses the new pc (e.g. 0x80000100).
REQ-035 rresp=2'b10: if_id_inst=0x00000013 and if_id_fault=1.
REQ-036 HOLD with if_id_ready=0 for 3 cycles: if_id_* stable, no new arvalid; release gives IDLE and then a request to pc+4.
REQ-037 rst driven low while in ADDR: arvalid=0 immediately (asynchronous), FSM IDLE.
